// File: rtl/cavlc_pkg.sv
// Shared constants and helpers for the CAVLC FIFO slice.
package cavlc_pkg;

  localparam int CAVLC_FIFO_W = 16;
  localparam int CAVLC_FIFO_D = 8;

  // Number of address bits needed to index value entries (ceil log2).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cavlc_fifo_ram.sv
// Storage array for the CAVLC FIFO: one synchronous write port, one asynchronous read port.
module cavlc_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_Clk,
  input  logic              i_WrEn,
  input  logic [ADDR_W-1:0] i_WrAddr,
  input  logic [DATA_W-1:0] i_WrData,
  input  logic [ADDR_W-1:0] i_RdAddr,
  output logic [DATA_W-1:0] o_RdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately left unreset; control logic never exposes unwritten entries as valid.
  always_ff @(posedge i_Clk) begin
    if (i_WrEn) r_mem[i_WrAddr] <= i_WrData;
  end

  assign o_RdData = r_mem[i_RdAddr];

endmodule

// File: rtl/cavlc_sync_fifo.sv
// Single-clock FIFO with registered flags, occupancy count, overflow/underflow strobes,
// flush, and a selectable registered or first-word-fall-through read stage.
module cavlc_sync_fifo
  import cavlc_pkg::*;
#(
  parameter int DATA_W = CAVLC_FIFO_W,
  parameter int DEPTH  = CAVLC_FIFO_D,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Flush,
  input  logic                  i_WrEn,
  input  logic [DATA_W-1:0]     i_WrData,
  input  logic                  i_RdEn,
  output logic [DATA_W-1:0]     o_RdData,
  output logic                  o_RdValid,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic                  o_AlmostFull,
  output logic                  o_AlmostEmpty,
  output logic [clog2(DEPTH):0] o_Count,
  output logic                  o_Overflow,
  output logic                  o_Underflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
      $error("cavlc_sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_badAf
      $error("cavlc_sync_fifo: AF_LVL must lie in 1..DEPTH");
    end
    if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_badAe
      $error("cavlc_sync_fifo: AE_LVL must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_almostFull;
  logic              r_almostEmpty;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_wrOk;
  logic              w_rdOk;
  logic [CNT_W-1:0]  w_cntNext;
  logic [DATA_W-1:0] w_ramRd;

  // Acceptance uses the registered flags, so a read at Full frees no room for a same-cycle write.
  assign w_wrOk = i_WrEn & ~r_full;
  assign w_rdOk = i_RdEn & ~r_empty;

  always_comb begin
    w_cntNext = r_count;
    if (w_wrOk && !w_rdOk) w_cntNext = r_count + 1'b1;
    else if (w_rdOk && !w_wrOk) w_cntNext = r_count - 1'b1;
  end

  cavlc_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .i_Clk    (i_Clk),
    .i_WrEn   (w_wrOk & ~i_Flush),
    .i_WrAddr (r_wrPtr),
    .i_WrData (i_WrData),
    .i_RdAddr (r_rdPtr),
    .o_RdData (w_ramRd)
  );

  // Flags are registered from the next count so they always agree with o_Count.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else if (i_Flush) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_wrOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_rdOk) r_rdPtr <= r_rdPtr + 1'b1;
      r_count       <= w_cntNext;
      r_full        <= (w_cntNext == CNT_W'(DEPTH));
      r_empty       <= (w_cntNext == '0);
      r_almostFull  <= (w_cntNext >= CNT_W'(AF_LVL));
      r_almostEmpty <= (w_cntNext <= CNT_W'(AE_LVL));
      r_overflow    <= i_WrEn & r_full;
      r_underflow   <= i_RdEn & r_empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_RdData  = w_ramRd;
      assign o_RdValid = ~r_empty;
    end else begin : g_regRead
      logic [DATA_W-1:0] r_rdData;
      logic              r_rdValid;

      // RdData holds the last popped word; RdValid marks only the cycle it was refreshed.
      always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
          r_rdData  <= '0;
          r_rdValid <= 1'b0;
        end else if (i_Flush) begin
          r_rdValid <= 1'b0;
        end else begin
          r_rdValid <= w_rdOk;
          if (w_rdOk) r_rdData <= w_ramRd;
        end
      end

      assign o_RdData  = r_rdData;
      assign o_RdValid = r_rdValid;
    end
  endgenerate

  assign o_Count       = r_count;
  assign o_Full        = r_full;
  assign o_Empty       = r_empty;
  assign o_AlmostFull  = r_almostFull;
  assign o_AlmostEmpty = r_almostEmpty;
  assign o_Overflow    = r_overflow;
  assign o_Underflow   = r_underflow;

endmodule

// File: tb/tb_cavlc_sync_fifo.sv
// Directed bench for cavlc_sync_fifo: a registered-read instance driven from a vector table
// plus hand sequences, and a first-word-fall-through instance for the head-of-queue behaviour.
module tb_cavlc_sync_fifo;

  logic        clk;
  logic        reset;
  logic        flush0, wrEn0, rdEn0;
  logic [15:0] wrData0;
  logic        flush1, wrEn1, rdEn1;
  logic [15:0] wrData1;

  logic [15:0] rdData0, rdData1;
  logic        rdValid0, rdValid1;
  logic        full0, full1, empty0, empty1;
  logic        aFull0, aFull1, aEmpty0, aEmpty1;
  logic [3:0]  count0, count1;
  logic        ovf0, ovf1, unf0, unf1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr;
    logic [15:0] wd;
    logic        rd;
    logic        fl;
    logic [15:0] eData;
    logic        eValid;
    logic [3:0]  eCount;
    logic        eFull;
    logic        eEmpty;
    logic        eAf;
    logic        eAe;
    logic        eOvf;
    logic        eUnf;
  } vec_t;

  vec_t table0[$];

  cavlc_sync_fifo #(.DATA_W(16), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(0)) u_dut0 (
    .i_Clk(clk), .i_Reset(reset), .i_Flush(flush0), .i_WrEn(wrEn0), .i_WrData(wrData0),
    .i_RdEn(rdEn0), .o_RdData(rdData0), .o_RdValid(rdValid0), .o_Full(full0), .o_Empty(empty0),
    .o_AlmostFull(aFull0), .o_AlmostEmpty(aEmpty0), .o_Count(count0),
    .o_Overflow(ovf0), .o_Underflow(unf0)
  );

  cavlc_sync_fifo #(.DATA_W(16), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(1)) u_dut1 (
    .i_Clk(clk), .i_Reset(reset), .i_Flush(flush1), .i_WrEn(wrEn1), .i_WrData(wrData1),
    .i_RdEn(rdEn1), .o_RdData(rdData1), .o_RdValid(rdValid1), .o_Full(full1), .o_Empty(empty1),
    .o_AlmostFull(aFull1), .o_AlmostEmpty(aEmpty1), .o_Count(count1),
    .o_Overflow(ovf1), .o_Underflow(unf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic wr, input logic [15:0] wd, input logic rd,
                              input logic fl, input logic [15:0] d, input logic v,
                              input logic [3:0] c, input logic f, input logic e,
                              input logic af, input logic ae, input logic ov, input logic un);
    vec_t r;
    r.wr = wr; r.wd = wd; r.rd = rd; r.fl = fl;
    r.eData = d; r.eValid = v; r.eCount = c; r.eFull = f; r.eEmpty = e;
    r.eAf = af; r.eAe = ae; r.eOvf = ov; r.eUnf = un;
    return r;
  endfunction

  // Drive one cycle of inputs on the selected instance, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic sel, input logic wr, input logic [15:0] wd,
                               input logic rd, input logic fl);
    if (sel) begin
      wrEn1 = wr; wrData1 = wd; rdEn1 = rd; flush1 = fl;
    end else begin
      wrEn0 = wr; wrData0 = wd; rdEn0 = rd; flush0 = fl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic checkAll0(input int idx, input logic [15:0] d, input logic v, input logic [3:0] c,
                           input logic f, input logic e, input logic af, input logic ae,
                           input logic ov, input logic un);
    checkOutput("RdData", idx, 32'(rdData0), 32'(d));
    checkOutput("RdValid", idx, 32'(rdValid0), 32'(v));
    checkOutput("Count", idx, 32'(count0), 32'(c));
    checkOutput("Full", idx, 32'(full0), 32'(f));
    checkOutput("Empty", idx, 32'(empty0), 32'(e));
    checkOutput("AlmostFull", idx, 32'(aFull0), 32'(af));
    checkOutput("AlmostEmpty", idx, 32'(aEmpty0), 32'(ae));
    checkOutput("Overflow", idx, 32'(ovf0), 32'(ov));
    checkOutput("Underflow", idx, 32'(unf0), 32'(un));
  endtask

  initial begin
    reset = 1'b1;
    flush0 = 1'b0; wrEn0 = 1'b0; rdEn0 = 1'b0; wrData0 = 16'h0;
    flush1 = 1'b0; wrEn1 = 1'b0; rdEn1 = 1'b0; wrData1 = 16'h0;
    #12;
    checkAll0(0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    // Fill to full, reject a write, drain, underflow, and the empty write+read corner.
    for (int i = 1; i <= 8; i++) begin
      table0.push_back(mk(1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 1'b0, 4'(i), (i == 8),
                          1'b0, (i >= 6), (i <= 2), 1'b0, 1'b0));
    end
    table0.push_back(mk(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    table0.push_back(mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 8; i++) begin
      table0.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, 16'(i), 1'b1, 4'(8 - i), 1'b0,
                          (i == 8), ((8 - i) >= 6), ((8 - i) <= 2), 1'b0, 1'b0));
    end
    table0.push_back(mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h8, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    table0.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h8, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    table0.push_back(mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h8, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    table0.push_back(mk(1'b1, 16'h0011, 1'b1, 1'b0, 16'h8, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    table0.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h0011, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 1; i <= 4; i++) begin
      table0.push_back(mk(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 16'h0011, 1'b0, 4'(i), 1'b0,
                          1'b0, 1'b0, (i <= 2), 1'b0, 1'b0));
    end

    foreach (table0[k]) begin
      applyStimulus(1'b0, table0[k].wr, table0[k].wd, table0[k].rd, table0[k].fl);
      checkAll0(100 + k, table0[k].eData, table0[k].eValid, table0[k].eCount, table0[k].eFull,
                table0[k].eEmpty, table0[k].eAf, table0[k].eAe, table0[k].eOvf, table0[k].eUnf);
    end

    // Steady streaming at Count=4 across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 16'(16'h0105 + i), 1'b1, 1'b0);
      checkAll0(200 + i, 16'(16'h0101 + i), 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'(16'h0119 + i), 1'b0, 1'b0);
    checkOutput("CountRefill", 300, 32'(count0), 32'd8);
    applyStimulus(1'b0, 1'b1, 16'h0BAD, 1'b1, 1'b0);
    checkAll0(301, 16'h0115, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Flush overrides a simultaneous write and read.
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkAll0(400, 16'h0115, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
    checkOutput("CountBeforeFlush", 401, 32'(count0), 32'd5);
    applyStimulus(1'b0, 1'b1, 16'h0EEE, 1'b1, 1'b1);
    checkAll0(402, 16'h0115, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a burst.
    applyStimulus(1'b0, 1'b1, 16'h0301, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0302, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0303, 1'b1, 1'b0);
    checkAll0(500, 16'h0301, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    checkAll0(501, 16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    wrEn0 = 1'b0; rdEn0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // First-word-fall-through instance.
    checkOutput("FwftValidIdle", 600, 32'(rdValid1), 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h00AA, 1'b0, 1'b0);
    checkOutput("FwftData", 601, 32'(rdData1), 32'h00AA);
    checkOutput("FwftValid", 601, 32'(rdValid1), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("FwftEmpty", 602, 32'(empty1), 32'd1);
    checkOutput("FwftValidDrop", 602, 32'(rdValid1), 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h00BB, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h00CC, 1'b0, 1'b0);
    checkOutput("FwftHead", 603, 32'(rdData1), 32'h00BB);
    checkOutput("FwftCount", 603, 32'(count1), 32'd2);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("FwftNextHead", 604, 32'(rdData1), 32'h00CC);
    checkOutput("FwftValidHeld", 604, 32'(rdValid1), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
